// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetch queue with in-order cache reads and redirect; IF_PREFETCH_PERF_EN adds perf counters
module if_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_reset_flag_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic [ADDR_W-1:0] o_p_addr,
  output logic              o_p_read,
  output logic              o_p_write,
  input  logic [DATA_W-1:0] i_p_readdata,
  input  logic              i_p_readdata_valid,
  input  logic              i_p_waitrequest
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]       perf_inst_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int SW = (CW > OW ? CW : OW) + 1;
  logic [ADDR_W-1:0] fpc, rpc, jump_pc;
  logic [OW-1:0] outst, drop, outst_nxt;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
  logic srst, accept, resp, discard, push, pop;
  // request issue, response classification and head presentation
  always_comb begin
    srst = rst | jtag_reset_flag_i;
    jump_pc = jump_addr_i & ~ADDR_W'(3);
    o_p_addr = fpc & ~ADDR_W'(3);
    o_p_write = 1'b0;
    o_p_read = !srst && !jump_flag_i && outst < OW'(MAX_OUTST) && (SW'(count) + SW'(outst)) < SW'(DEPTH);
    accept = o_p_read && !i_p_waitrequest;
    resp = i_p_readdata_valid && outst != '0 && !srst;
    discard = resp && (jump_flag_i || drop != '0);
    push = resp && !discard;
    inst_valid_o = count != '0 && !srst && !jump_flag_i;
    pop = inst_valid_o && !hold_i;
    {inst_addr_o, inst_o} = mem[rd_ptr];
    outst_nxt = outst + OW'(accept) - OW'(resp);
  end
  // fetch/response pointers, in-flight accounting and queue occupancy
  always_ff @(posedge clk) begin
    if (srst) begin
      fpc <= RESET_PC;
      rpc <= RESET_PC;
      outst <= '0;
      drop <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      fpc <= jump_flag_i ? jump_pc : accept ? fpc + ADDR_W'(4) : fpc;
      rpc <= jump_flag_i ? jump_pc : push ? rpc + ADDR_W'(4) : rpc;
      outst <= outst_nxt;
      drop <= jump_flag_i ? outst_nxt : drop - OW'(discard);
      count <= jump_flag_i ? '0 : count + CW'(push) - CW'(pop);
      rd_ptr <= jump_flag_i ? '0 : rd_ptr + PW'(pop);
      wr_ptr <= jump_flag_i ? '0 : wr_ptr + PW'(push);
    end
  end
  // queue storage, written with the address the response belongs to
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rpc, i_p_readdata};
  end
`ifdef IF_PREFETCH_PERF_EN
  // delivered-instruction and discarded-response counters
  always_ff @(posedge clk) begin
    perf_inst_cnt <= srst ? '0 : perf_inst_cnt + 32'(pop);
    perf_drop_cnt <= srst ? '0 : perf_drop_cnt + 32'(discard);
  end
`endif
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: scoreboard bench for if_prefetch with an in-order latency cache model
module tb_if_prefetch;
  logic clk = 1'b0;
  logic rst, jtag, jump, hold, waitreq, rvalid;
  logic [31:0] jaddr, rdata;
  logic [31:0] inst, inst_addr, p_addr;
  logic inst_valid, p_read, p_write;
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_inst_cnt, perf_drop_cnt;
`endif
  int errs = 0, checks = 0, pops = 0, cyc = 0, lat = 1, p0;
  logic [31:0] exp_q[$], pa[$];
  int pd[$];

  if_prefetch dut (
    .clk(clk), .rst(rst), .jtag_reset_flag_i(jtag), .jump_flag_i(jump), .jump_addr_i(jaddr),
    .hold_i(hold), .inst_o(inst), .inst_addr_o(inst_addr), .inst_valid_o(inst_valid),
    .o_p_addr(p_addr), .o_p_read(p_read), .o_p_write(p_write),
    .i_p_readdata(rdata), .i_p_readdata_valid(rvalid), .i_p_waitrequest(waitreq)
`ifdef IF_PREFETCH_PERF_EN
    , .perf_inst_cnt(perf_inst_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fd(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL %s_drain: %0d instructions undelivered, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // cache model: in-order responses lat cycles after acceptance
  always @(negedge clk) begin
    if (pa.size() != 0 && pd[0] <= cyc) begin
      rvalid = 1'b1;
      rdata = fd(pa[0]);
      void'(pa.pop_front());
      void'(pd.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata = 32'h0;
    end
    if (p_read && !waitreq) begin
      pa.push_back(p_addr);
      pd.push_back(cyc + lat);
    end
  end

  // monitor: every pop is compared against the next expected instruction
  always @(negedge clk) begin
    if (inst_valid && !hold) begin
      pops++;
      if (exp_q.size() != 0) begin
        chk("head_addr", inst_addr, exp_q[0]);
        chk("head_data", inst, fd(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; jtag = 0; hold = 0; jump = 0; jaddr = 0; waitreq = 0; rvalid = 0; rdata = 0; lat = 1;
    tick(3);
    @(negedge clk);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_read", 32'(p_read), 0);
    chk("write_tied", 32'(p_write), 0);
    tick(1);
    expect_seq(32'h0, 8); rst = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("seq_read", 32'(p_read), 1);
      chk("seq_addr", p_addr, 32'(4 * i));
    end
    tick(1);
    wait_drain("seq");

    hold = 1; rst = 1; expect_seq(32'h0, 4);
    tick(4); rst = 0;
    tick(10);
    @(negedge clk);
    chk("hold_valid", 32'(inst_valid), 1);
    chk("hold_head", inst_addr, 32'h0);
    chk("hold_read", 32'(p_read), 0);
`ifdef IF_PREFETCH_PERF_EN
    chk("perf_inst_held", perf_inst_cnt, 0);
`endif
    tick(1);
    p0 = pops; hold = 0;
    tick(4);
    chk("hold_release_pops", 32'(pops - p0), 4);
`ifdef IF_PREFETCH_PERF_EN
    chk("perf_inst_released", perf_inst_cnt, 4);
`endif
    wait_drain("hold");

    jtag = 1; lat = 1; expect_seq(32'h0, 6);
    tick(4); jtag = 0;
    tick(3); waitreq = 1;
    repeat (3) begin
      @(negedge clk);
      chk("wait_addr", p_addr, 32'hC);
      chk("wait_read", 32'(p_read), 1);
    end
    tick(1); waitreq = 0;
    @(negedge clk);
    chk("wait_release_addr", p_addr, 32'hC);
    @(negedge clk);
    chk("wait_next_addr", p_addr, 32'h10);
    tick(1);
    wait_drain("wait");

    rst = 1; lat = 3; expect_seq(32'h100, 3);
    tick(4); rst = 0;
    tick(2); jump = 1; jaddr = 32'h103;
    @(negedge clk);
    chk("jump_read", 32'(p_read), 0);
    chk("jump_valid", 32'(inst_valid), 0);
    tick(1); jump = 0;
    @(negedge clk);
    chk("jump_target", p_addr, 32'h100);
    tick(1);
    wait_drain("jump");
`ifdef IF_PREFETCH_PERF_EN
    chk("perf_drop_jump", perf_drop_cnt, 2);
`endif

    rst = 1; lat = 2; expect_seq(32'h300, 3);
    tick(4); rst = 0;
    tick(2); jump = 1; jaddr = 32'h200;
    tick(1); jaddr = 32'h300;
    @(negedge clk);
    chk("jump2_read", 32'(p_read), 0);
    tick(1); jump = 0;
    wait_drain("double_jump");
`ifdef IF_PREFETCH_PERF_EN
    chk("perf_drop_double", perf_drop_cnt, 2);
`endif

    rst = 1; expect_seq(32'h0, 4);
    tick(1); rst = 0;
    wait_drain("short_reset");

    jump = 1; jaddr = 32'hFFFF_FFF8; lat = 1; expect_seq(32'hFFFF_FFF8, 4);
    tick(1); jump = 0;
    @(negedge clk);
    chk("wrap_addr0", p_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap_addr1", p_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr2", p_addr, 32'h0);
    tick(1);
    wait_drain("wrap");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
